// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of JK flip-flops: drives J/K to clear, set,
// toggle or count the bank, and pulses done once the bank holds the result.
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_UP     = 3'd4;
    localparam logic [2:0] OP_DN     = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_COUNT,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   up_t, dn_t, cnt_t;

    // Toggle masks of a synchronous counter built from the bank itself
    always_comb begin
        logic run_u;
        logic run_d;
        run_u = 1'b1;
        run_d = 1'b1;
        up_t  = '0;
        dn_t  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = run_u;
            dn_t[i] = run_d;
            run_u   = run_u & q_fb[i];
            run_d   = run_d & ~q_fb[i];
        end
    end

    assign cnt_t = (op_q == OP_DN) ? dn_t : up_t;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            mask_q <= '0;
            rem_q  <= '0;
        end else begin
            state  <= state_d;
            op_q   <= op_d;
            mask_q <= mask_d;
            rem_q  <= rem_d;
        end
    end

    always_comb begin
        state_d = state;
        op_d    = op_q;
        mask_d  = mask_q;
        rem_d   = rem_q;
        jk_j    = '0;
        jk_k    = '0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    mask_d = cmd_mask;
                    rem_d  = cmd_count;
                    if (cmd_op == OP_CLEAR || cmd_op == OP_SET ||
                        cmd_op == OP_TOGGLE) begin
                        state_d = S_APPLY;
                    end else if ((cmd_op == OP_UP || cmd_op == OP_DN) &&
                                 cmd_count != '0) begin
                        state_d = S_COUNT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_APPLY: begin
                case (op_q)
                    OP_CLEAR:  jk_k = mask_q;
                    OP_SET:    jk_j = mask_q;
                    OP_TOGGLE: begin
                        jk_j = mask_q;
                        jk_k = mask_q;
                    end
                    default: ;
                endcase
                state_d = S_DONE;
            end
            S_COUNT: begin
                if (abort) begin
                    state_d = S_DONE;
                end else begin
                    jk_j  = cnt_t;
                    jk_k  = cnt_t;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule
